// File: rtl/regfile_pkg.sv
// Shared register-file writeback types and constants.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 4;
  localparam int unsigned RF_DATA_W = 32;

  // Register 0 reads as zero, so writes to it are dropped.
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_dec.sv
// Parameterized enable-decoder: N-bit code to 2^N one-hot, all-zero when disabled.
module regfile_write_arbiter_dec #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]    i_code,
  input  logic            i_en,
  output logic [2**N-1:0] o_onehot
);

  // Decode the code into a single set bit while enabled.
  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_code] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among R writeback requesters.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned R = 4,
  parameter int unsigned N = RF_ADDR_W,
  parameter int unsigned W = RF_DATA_W,
  localparam int unsigned IdW = $clog2(R)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [R-1:0]    i_req_valid,
  input  logic [R*N-1:0]  i_req_addr,
  input  logic [R*W-1:0]  i_req_data,
  output logic [R-1:0]    o_req_ready,
  input  logic            i_wb_stall,
  output logic [N-1:0]    o_wr_code,
  output logic [W-1:0]    o_wr_data,
  output logic            o_wr_en,
  output logic [2**N-1:0] o_wr_onehot,
  output logic [IdW-1:0]  o_grant_id
);

  logic [IdW-1:0] r_ptr;
  logic           r_wr_en;
  logic [N-1:0]   r_wr_code;
  logic [W-1:0]   r_wr_data;
  logic [IdW-1:0] r_grant_id;

  logic [N-1:0]   w_addr [R];
  logic [W-1:0]   w_data [R];
  logic           w_gnt_vld;
  logic [IdW-1:0] w_gnt_idx;
  logic [IdW-1:0] w_scan;
  logic [N-1:0]   w_sel_addr;
  logic [W-1:0]   w_sel_data;

  for (genvar g = 0; g < R; g++) begin : g_unpack
    assign w_addr[g] = i_req_addr[g*N +: N];
    assign w_data[g] = i_req_data[g*W +: W];
  end

  // Scan requesters starting at the priority pointer; the first valid one wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int unsigned k = 0; k < R; k++) begin
      w_scan = IdW'((32'(r_ptr) + k) % R);
      if (!w_gnt_vld && i_req_valid[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
    // No grants while the port is stalled or the block is held in reset.
    if (i_wb_stall || !i_rst_n) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_sel_addr  = w_addr[w_gnt_idx];
  assign w_sel_data  = w_data[w_gnt_idx];
  assign o_req_ready = w_gnt_vld ? (R'(1) << w_gnt_idx) : '0;

  // Capture the winner and advance the pointer; a stall freezes everything.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_code  <= '0;
      r_wr_data  <= '0;
      r_grant_id <= '0;
    end else if (!i_wb_stall) begin
      if (w_gnt_vld) begin
        // A grant to register 0 is consumed but never written.
        r_wr_en    <= (w_sel_addr != N'(REG_ZERO));
        r_wr_code  <= w_sel_addr;
        r_wr_data  <= w_sel_data;
        r_grant_id <= w_gnt_idx;
        r_ptr      <= (w_gnt_idx == IdW'(R - 1)) ? '0 : w_gnt_idx + IdW'(1);
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign o_wr_en    = r_wr_en;
  assign o_wr_code  = r_wr_code;
  assign o_wr_data  = r_wr_data;
  assign o_grant_id = r_grant_id;

  regfile_write_arbiter_dec #(
    .N (N)
  ) u_dec (
    .i_code   (r_wr_code),
    .i_en     (r_wr_en & ~i_wb_stall),
    .o_onehot (o_wr_onehot)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed check of regfile_write_arbiter against a behavioural model.
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int unsigned R = 4;
  localparam int unsigned N = RF_ADDR_W;
  localparam int unsigned W = RF_DATA_W;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [R-1:0]    req_valid;
  logic [R*N-1:0]  req_addr;
  logic [R*W-1:0]  req_data;
  logic [R-1:0]    req_ready;
  logic            wb_stall;
  logic [N-1:0]    wr_code;
  logic [W-1:0]    wr_data;
  logic            wr_en;
  logic [2**N-1:0] wr_onehot;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .R (R),
    .N (N),
    .W (W)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_addr  (req_addr),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .i_wb_stall  (wb_stall),
    .o_wr_code   (wr_code),
    .o_wr_data   (wr_data),
    .o_wr_en     (wr_en),
    .o_wr_onehot (wr_onehot),
    .o_grant_id  (grant_id)
  );

  // Requester side: pending request per requester, held until granted.
  bit [R-1:0] p_valid;
  wb_req_t    p_req [R];

  // Model of the output register and priority pointer.
  int         m_ptr;
  bit         m_en;
  logic [N-1:0] m_code;
  logic [W-1:0] m_data;
  int         m_id;

  int  n_pass  = 0;
  int  n_total = 0;
  bit  fair_on = 1'b0;
  int  wt [R];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Winner is the valid requester at the smallest circular distance from the pointer.
  function automatic int model_grant();
    int best;
    int bestd;
    best  = -1;
    bestd = R;
    if (!rst_n || wb_stall) return -1;
    for (int i = 0; i < R; i++) begin
      if (p_valid[i] && ((i - m_ptr + R) % R) < bestd) begin
        bestd = (i - m_ptr + R) % R;
        best  = i;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_ptr  = 0;
    m_en   = 1'b0;
    m_code = '0;
    m_data = '0;
    m_id   = 0;
    for (int i = 0; i < R; i++) wt[i] = 0;
  endtask

  task automatic drive();
    req_valid = p_valid;
    for (int i = 0; i < R; i++) begin
      req_addr[i*N +: N] = p_req[i].addr;
      req_data[i*W +: W] = p_req[i].data;
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [W-1:0] d);
    p_valid[i]    = 1'b1;
    p_req[i].addr = a;
    p_req[i].data = d;
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g;
    logic [R-1:0] er;
    logic [2**N-1:0] eoh;
    drive();
    @(negedge clk);
    g   = model_grant();
    er  = (g >= 0) ? (R'(1) << g) : '0;
    eoh = (m_en && !wb_stall) ? ((2**N)'(1) << m_code) : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("wr_en", 64'(wr_en), 64'(m_en));
    chk("wr_code", 64'(wr_code), 64'(m_code));
    chk("wr_data", 64'(wr_data), 64'(m_data));
    chk("grant_id", 64'(grant_id), 64'(m_id));
    chk("wr_onehot", 64'(wr_onehot), 64'(eoh));
    if (fair_on && rst_n && !wb_stall) begin
      for (int i = 0; i < R; i++) begin
        if (p_valid[i]) begin
          if (req_ready[i]) begin
            chk("fair_wait", 64'(wt[i] < R), 64'(1));
            wt[i] = 0;
          end else begin
            wt[i]++;
          end
        end
      end
    end
    @(posedge clk);
    if (rst_n && !wb_stall) begin
      if (g >= 0) begin
        m_en   = (p_req[g].addr != REG_ZERO);
        m_code = p_req[g].addr;
        m_data = p_req[g].data;
        m_id   = g;
        m_ptr  = (g + 1) % R;
        p_valid[g] = 1'b0;
      end else begin
        m_en = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_order [5];
    rst_n    = 1'b0;
    wb_stall = 1'b0;
    p_valid  = '0;
    for (int i = 0; i < R; i++) p_req[i] = '0;
    drive();
    do_reset();

    // After reset release, requester 0 alone is granted immediately.
    set_req(0, 4'd9, 32'h1111_0000);
    drive();
    #1;
    chk("rst_rel_ready", 64'(req_ready), 64'(4'b0001));
    cycle();

    // Single requester 2 writes register 5.
    set_req(2, 4'd5, 32'hDEAD_BEEF);
    drive();
    #1;
    chk("single_ready", 64'(req_ready), 64'(4'b0100));
    cycle();
    drive();
    #1;
    chk("single_onehot", 64'(wr_onehot), 64'(16'h0020));
    chk("single_data", 64'(wr_data), 64'(32'hDEAD_BEEF));

    // Reset mid-run with a live entry drops it at once.
    set_req(1, 4'd3, 32'h0BAD_F00D);
    cycle();
    rst_n = 1'b0;
    #1;
    chk("midrst_en", 64'(wr_en), 64'(0));
    chk("midrst_onehot", 64'(wr_onehot), 64'(0));
    chk("midrst_data", 64'(wr_data), 64'(0));
    model_reset();
    p_valid = '0;
    cycle();
    rst_n = 1'b1;

    // Full contention from pointer 0: order 0,1,2,3,0.
    exp_order = '{0, 1, 2, 3, 0};
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < R; i++) set_req(i, N'(i + 8), 32'hC000_0000 + 32'(c * 16 + i));
      cycle();
      chk("contend_id", 64'(grant_id), 64'(exp_order[c]));
    end
    p_valid = '0;

    // Stall: grant, then two stalled cycles, then the held entry is written.
    set_req(2, 4'd6, 32'h5A5A_0001);
    cycle();
    set_req(3, 4'd4, 32'h5A5A_0002);
    wb_stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      drive();
      #1;
      chk("stall_onehot", 64'(wr_onehot), 64'(0));
      chk("stall_ready", 64'(req_ready), 64'(0));
      cycle();
    end
    wb_stall = 1'b0;
    drive();
    #1;
    chk("unstall_onehot", 64'(wr_onehot), 64'(16'h0040));
    chk("unstall_ready", 64'(req_ready), 64'(4'b1000));
    cycle();
    cycle();

    // Register 0: consumed but not written; pointer moves to 2.
    set_req(1, 4'd0, 32'hFFFF_FFFF);
    cycle();
    drive();
    #1;
    chk("reg0_en", 64'(wr_en), 64'(0));
    chk("reg0_onehot", 64'(wr_onehot), 64'(0));
    for (int i = 0; i < R; i++) set_req(i, 4'd2, 32'h2222_0000 + 32'(i));
    cycle();
    chk("reg0_ptr", 64'(grant_id), 64'(2));
    p_valid = '0;

    // Same address from requesters 0 and 3 with pointer 3.
    set_req(0, 4'd7, 32'hAAAA_0000);
    set_req(3, 4'd7, 32'hBBBB_0003);
    cycle();
    chk("same_first", 64'(wr_data), 64'(32'hBBBB_0003));
    cycle();
    chk("same_second", 64'(wr_data), 64'(32'hAAAA_0000));
    cycle();

    // Randomized traffic with occasional stalls and resets.
    for (int i = 0; i < R; i++) wt[i] = 0;
    fair_on = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(59, 0) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      for (int i = 0; i < R; i++) begin
        if (!p_valid[i] && $urandom_range(1, 0) == 1) begin
          set_req(i, N'($urandom_range(15, 0)), $urandom);
          wt[i] = 0;
        end
      end
      wb_stall = ($urandom_range(3, 0) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
